axis_s_ingress_ctrl: RTL and testbench

Sequencer between the AXI-Stream slave input FIFO and the internal feature/weight write path. Pops FIFO entries ({keep count, tlast, tdata}), splits each 32-bit beat into 16-bit external words (lowest half first), widens each word to internal arithmetic precision (external word in the MSBs, zero-filled fraction LSBs), and streams words out under valid/ready. Started by a regmap command; reports completion, transfer length and framing errors back to the regmap.

---
 rtl/axis_s_ingress_ctrl_if.sv | 27 ++
 rtl/axis_s_ingress_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_axis_s_ingress_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_s_ingress_ctrl_if.sv
// Handshake bundle between the AXIS ingress sequencer, its input FIFO and the
// internal feature/weight write path. The sequencer uses the slave modport;
// the surrounding environment (FIFO + consumer) uses the master modport.
interface axis_s_ingress_ctrl_if #(
    parameter int C_S_FIFO_WDT     = 36,
    parameter int C_ARITH_WORD_LEN = 24
);
    // FIFO read side
    logic [C_S_FIFO_WDT-1:0]     fifo_rd_data;
    logic                        fifo_empty;
    logic                        fifo_rd_en;
    // Converted word stream
    logic [C_ARITH_WORD_LEN-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_last;

    modport slave (
        input  fifo_rd_data, fifo_empty, out_ready,
        output fifo_rd_en, out_data, out_valid, out_last
    );

    modport master (
        output fifo_rd_data, fifo_empty, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_last
    );
endinterface

// File: rtl/axis_s_ingress_ctrl.sv
// AXI-Stream slave ingress sequencer: pops {keep count, tlast, tdata} FIFO
// entries, splits each beat into external words (lowest first), widens each
// word to internal precision (word in MSBs, zero fraction) and streams the
// words out under valid/ready. Reports completion, word count and framing
// errors to the regmap.
// Optional build macro: AXIS_INGRESS_LEN_CHK_EN enables the expected-length
// check (err_len); without it word_cnt_exp is ignored and err_len stays 0.
module axis_s_ingress_ctrl #(
    parameter int C_S_TDATA_WDT         = 32,
    parameter int C_EXT_DATA_WORD_WDT   = 16,
    parameter int C_ARITH_WORD_LEN      = 24,
    parameter int C_S_FIFO_WDT          = C_S_TDATA_WDT + 1 + $clog2(C_S_TDATA_WDT / 8 + 1),
    parameter int C_S_AXIS_DONE_CYC_LEN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          word_cnt_exp,
    axis_s_ingress_ctrl_if.slave bus,
    output logic                 busy,
    output logic                 done,
    output logic [15:0]          word_cnt,
    output logic                 err_odd,
    output logic                 err_len
);
    localparam int KEEP_W         = $clog2(C_S_TDATA_WDT / 8 + 1);
    localparam int BYTES_PER_WORD = C_EXT_DATA_WORD_WDT / 8;
    localparam int WORDS_PER_BEAT = C_S_TDATA_WDT / C_EXT_DATA_WORD_WDT;
    localparam int IDX_W          = $clog2(WORDS_PER_BEAT + 1);
    localparam int DONE_CNT_W     = $clog2(C_S_AXIS_DONE_CYC_LEN + 1);
    localparam int FRAC_W         = C_ARITH_WORD_LEN - C_EXT_DATA_WORD_WDT;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_UNPACK,
        S_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [C_S_TDATA_WDT-1:0]    tdata_q, tdata_d;
    logic                        tlast_q, tlast_d;
    logic [IDX_W-1:0]            words_q, words_d;
    logic [IDX_W-1:0]            idx_q, idx_d;
    logic [C_ARITH_WORD_LEN-1:0] out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_last_q, out_last_d;
    logic [15:0]                 word_cnt_q, word_cnt_d;
    logic                        err_odd_q, err_odd_d;
    logic                        err_len_q, err_len_d;
    logic [DONE_CNT_W-1:0]       done_cnt_q, done_cnt_d;
    logic                        rd_en;
    logic                        word_acc;
    logic                        enter_done;

`ifdef AXIS_INGRESS_LEN_CHK_EN
    logic [15:0]                 exp_q, exp_d;
`else
    logic                        unused_word_cnt_exp;
    assign unused_word_cnt_exp = ^word_cnt_exp;
`endif

    logic [C_S_TDATA_WDT-1:0]    fifo_tdata;
    logic                        fifo_tlast;
    logic [KEEP_W-1:0]           fifo_keep;
    logic [KEEP_W-1:0]           words_raw;
    logic [IDX_W-1:0]            beat_words;
    logic                        beat_odd;

    // Select word idx of a beat and place it in the MSBs of an internal word.
    function automatic logic [C_ARITH_WORD_LEN-1:0] widen(
        input logic [C_S_TDATA_WDT-1:0] data,
        input logic [IDX_W-1:0]         idx
    );
        logic [C_EXT_DATA_WORD_WDT-1:0] word;
        word = C_EXT_DATA_WORD_WDT'(data >> (int'(idx) * C_EXT_DATA_WORD_WDT));
        return C_ARITH_WORD_LEN'(word) << FRAC_W;
    endfunction

    // Decode the FIFO entry; malformed keep counts are clamped to a full beat.
    always_comb begin
        fifo_tdata = bus.fifo_rd_data[C_S_TDATA_WDT-1:0];
        fifo_tlast = bus.fifo_rd_data[C_S_TDATA_WDT];
        fifo_keep  = bus.fifo_rd_data[C_S_FIFO_WDT-1 -: KEEP_W];
        words_raw  = fifo_keep / KEEP_W'(BYTES_PER_WORD);
        beat_words = (words_raw > KEEP_W'(WORDS_PER_BEAT)) ? IDX_W'(WORDS_PER_BEAT)
                                                           : IDX_W'(words_raw);
        beat_odd   = (fifo_keep % KEEP_W'(BYTES_PER_WORD)) != '0;
    end

    // Next-state and datapath: fetch a beat, unpack its words, then report done.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it
        // unassigned; a missing default here would infer a latch.
        state_d     = state_q;
        tdata_d     = tdata_q;
        tlast_d     = tlast_q;
        words_d     = words_q;
        idx_d       = idx_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        word_cnt_d  = word_cnt_q;
        err_odd_d   = err_odd_q;
        err_len_d   = err_len_q;
        done_cnt_d  = done_cnt_q;
        rd_en       = 1'b0;
        enter_done  = 1'b0;
`ifdef AXIS_INGRESS_LEN_CHK_EN
        exp_d       = exp_q;
`endif

        word_acc = out_valid_q && bus.out_ready;
        if (word_acc && (word_cnt_q != 16'hFFFF)) begin
            word_cnt_d = word_cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d    = S_FETCH;
                    word_cnt_d = '0;
                    err_odd_d  = 1'b0;
                    err_len_d  = 1'b0;
`ifdef AXIS_INGRESS_LEN_CHK_EN
                    exp_d      = word_cnt_exp;
`endif
                end
            end
            S_FETCH: begin
                if (!bus.fifo_empty) begin
                    rd_en   = 1'b1;
                    state_d = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                tdata_d = fifo_tdata;
                tlast_d = fifo_tlast;
                words_d = beat_words;
                idx_d   = '0;
                if (beat_odd) begin
                    err_odd_d = 1'b1;
                end
                if (beat_words == '0) begin
                    state_d    = fifo_tlast ? S_DONE : S_FETCH;
                    enter_done = fifo_tlast;
                end else begin
                    state_d     = S_UNPACK;
                    out_valid_d = 1'b1;
                    out_data_d  = widen(fifo_tdata, '0);
                    out_last_d  = fifo_tlast && (beat_words == IDX_W'(1));
                end
            end
            S_UNPACK: begin
                if (word_acc) begin
                    if (idx_q == words_q - IDX_W'(1)) begin
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        state_d     = tlast_q ? S_DONE : S_FETCH;
                        enter_done  = tlast_q;
                    end else begin
                        idx_d      = idx_q + IDX_W'(1);
                        out_data_d = widen(tdata_q, idx_q + IDX_W'(1));
                        out_last_d = tlast_q && (idx_q + IDX_W'(1) == words_q - IDX_W'(1));
                    end
                end
            end
            S_DONE: begin
                if (done_cnt_q == DONE_CNT_W'(C_S_AXIS_DONE_CYC_LEN - 1)) begin
                    state_d    = S_IDLE;
                    done_cnt_d = '0;
                end else begin
                    done_cnt_d = done_cnt_q + DONE_CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef AXIS_INGRESS_LEN_CHK_EN
        // Compare against the count including this cycle's final word.
        if (enter_done && (word_cnt_d != exp_q)) begin
            err_len_d = 1'b1;
        end
`endif
    end

    // State and output registers; reset drops any held beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            tdata_q     <= '0;
            tlast_q     <= 1'b0;
            words_q     <= '0;
            idx_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            word_cnt_q  <= '0;
            err_odd_q   <= 1'b0;
            err_len_q   <= 1'b0;
            done_cnt_q  <= '0;
`ifdef AXIS_INGRESS_LEN_CHK_EN
            exp_q       <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values computed by the combinational block.
            state_q     <= state_d;
            tdata_q     <= tdata_d;
            tlast_q     <= tlast_d;
            words_q     <= words_d;
            idx_q       <= idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            word_cnt_q  <= word_cnt_d;
            err_odd_q   <= err_odd_d;
            err_len_q   <= err_len_d;
            done_cnt_q  <= done_cnt_d;
`ifdef AXIS_INGRESS_LEN_CHK_EN
            exp_q       <= exp_d;
`endif
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_data   = out_data_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_last_q;
    assign busy           = state_q inside {S_FETCH, S_WAIT_RD, S_UNPACK};
    assign done           = (state_q == S_DONE);
    assign word_cnt       = word_cnt_q;
    assign err_odd        = err_odd_q;
    assign err_len        = err_len_q;
endmodule

// File: tb/tb_axis_s_ingress_ctrl.sv
// Directed self-checking bench for axis_s_ingress_ctrl: a small FIFO model
// feeds beats, a negedge monitor logs accepted words, done cycles and
// handshake rule violations, and the main sequence compares against
// hand-computed values.
module tb_axis_s_ingress_ctrl;
    localparam int TDATA_W  = 32;
    localparam int EXT_W    = 16;
    localparam int ARITH_W  = 24;
    localparam int FIFO_W   = TDATA_W + 1 + 3;
    localparam int DONE_LEN = 2;
    localparam int FRAC_W   = ARITH_W - EXT_W;

`ifdef AXIS_INGRESS_LEN_CHK_EN
    localparam logic LEN_CHK = 1'b1;
`else
    localparam logic LEN_CHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] word_cnt_exp;
    logic        busy;
    logic        done;
    logic [15:0] word_cnt;
    logic        err_odd;
    logic        err_len;

    axis_s_ingress_ctrl_if #(.C_S_FIFO_WDT(FIFO_W), .C_ARITH_WORD_LEN(ARITH_W)) bus_if ();

    axis_s_ingress_ctrl #(
        .C_S_TDATA_WDT        (TDATA_W),
        .C_EXT_DATA_WORD_WDT  (EXT_W),
        .C_ARITH_WORD_LEN     (ARITH_W),
        .C_S_FIFO_WDT         (FIFO_W),
        .C_S_AXIS_DONE_CYC_LEN(DONE_LEN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .word_cnt_exp(word_cnt_exp),
        .bus         (bus_if),
        .busy        (busy),
        .done        (done),
        .word_cnt    (word_cnt),
        .err_odd     (err_odd),
        .err_len     (err_len)
    );

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model: main sequence pushes, model pops on the edge after a request.
    logic [FIFO_W-1:0] mem [0:63];
    int                wr_cnt = 0;
    int                rd_cnt = 0;
    logic              pop_req = 1'b0;
    assign bus_if.fifo_empty = (wr_cnt == rd_cnt);

    always @(posedge clk) begin
        if (pop_req && (wr_cnt != rd_cnt)) begin
            bus_if.fifo_rd_data <= mem[rd_cnt % 64];
            rd_cnt              <= rd_cnt + 1;
        end
    end

    // Consumer ready pattern: 0 = always ready, 1 = toggle, 2 = held low.
    int ready_mode = 0;
    initial begin
        bus_if.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       bus_if.out_ready = ~bus_if.out_ready;
                2:       bus_if.out_ready = 1'b0;
                default: bus_if.out_ready = 1'b1;
            endcase
        end
    end

    // Monitor: sampled mid-cycle, away from the active edge.
    logic [ARITH_W-1:0] cap_data [0:63];
    logic               cap_last [0:63];
    int                 cap_n      = 0;
    int                 done_cyc   = 0;
    int                 stall_viol = 0;
    int                 rd_empty   = 0;
    int                 rd_unpack  = 0;
    logic               stall_prev = 1'b0;
    logic [ARITH_W-1:0] prev_data;
    logic               prev_last;

    initial begin
        forever begin
            @(negedge clk);
            pop_req = bus_if.fifo_rd_en;
            if (!rst) begin
                if (bus_if.out_valid && bus_if.out_ready && cap_n < 64) begin
                    cap_data[cap_n] = bus_if.out_data;
                    cap_last[cap_n] = bus_if.out_last;
                    cap_n++;
                end
                if (stall_prev && (!bus_if.out_valid || bus_if.out_data !== prev_data ||
                                   bus_if.out_last !== prev_last)) begin
                    stall_viol++;
                end
                stall_prev = bus_if.out_valid && !bus_if.out_ready;
                prev_data  = bus_if.out_data;
                prev_last  = bus_if.out_last;
                if (done) done_cyc++;
                if (bus_if.fifo_rd_en && bus_if.fifo_empty) rd_empty++;
                if (bus_if.fifo_rd_en && bus_if.out_valid) rd_unpack++;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] keep, input logic last, input logic [31:0] data);
        mem[wr_cnt % 64] = {keep, last, data};
        wr_cnt++;
    endtask

    task automatic run(input logic [15:0] exp);
        word_cnt_exp = exp;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int   n;
        logic saw;
        n   = 0;
        saw = 1'b0;
        while (!(saw && !busy && !done) && n < 300) begin
            @(negedge clk);
            if (done) saw = 1'b1;
            n++;
        end
        check({tag, "_timeout"}, 64'(n >= 300), 64'd0);
    endtask

    // Expected words are consecutive external values first..first+count-1.
    task automatic check_seq(input string tag, input int base, input int first, input int count);
        check({tag, "_count"}, 64'(cap_n - base), 64'(count));
        for (int i = 0; i < count; i++) begin
            check({tag, "_data"}, 64'(cap_data[(base + i) % 64]),
                  64'((first + i) & 16'hFFFF) << FRAC_W);
            check({tag, "_last"}, 64'(cap_last[(base + i) % 64]), 64'(i == count - 1));
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_rd_en"},     64'(bus_if.fifo_rd_en), 64'd0);
        check({tag, "_out_valid"}, 64'(bus_if.out_valid),  64'd0);
        check({tag, "_out_last"},  64'(bus_if.out_last),   64'd0);
        check({tag, "_out_data"},  64'(bus_if.out_data),   64'd0);
        check({tag, "_busy"},      64'(busy),              64'd0);
        check({tag, "_done"},      64'(done),              64'd0);
        check({tag, "_word_cnt"},  64'(word_cnt),          64'd0);
        check({tag, "_err_odd"},   64'(err_odd),           64'd0);
        check({tag, "_err_len"},   64'(err_len),           64'd0);
    endtask

    initial begin
        int base;
        int dbase;

        rst          = 1'b1;
        start        = 1'b0;
        word_cnt_exp = '0;
        #1;
        check_zero_outputs("reset");
        tick();
        tick();
        rst = 1'b0;
        tick();

        // 1: two full beats, always ready, exp = 4; checks start latency.
        push(3'd4, 1'b0, 32'h0002_0001);
        push(3'd4, 1'b1, 32'h0004_0003);
        base  = cap_n;
        dbase = done_cyc;
        run(16'd4);
        @(negedge clk);
        check("t1_rd_en_n1", 64'(bus_if.fifo_rd_en), 64'd1);
        check("t1_busy_n1", 64'(busy), 64'd1);
        @(negedge clk);
        check("t1_valid_n2", 64'(bus_if.out_valid), 64'd0);
        @(negedge clk);
        check("t1_valid_n3", 64'(bus_if.out_valid), 64'd1);
        check("t1_data_n3", 64'(bus_if.out_data), 64'h00_0100);
        wait_idle("t1");
        check_seq("t1", base, 1, 4);
        check("t1_word_cnt", 64'(word_cnt), 64'd4);
        check("t1_done_cyc", 64'(done_cyc - dbase), 64'(DONE_LEN));
        check("t1_err_odd", 64'(err_odd), 64'd0);
        check("t1_err_len", 64'(err_len), 64'd0);

        // 2: same beats, ready toggling every cycle.
        push(3'd4, 1'b0, 32'h0002_0001);
        push(3'd4, 1'b1, 32'h0004_0003);
        ready_mode = 1;
        base       = cap_n;
        run(16'd4);
        wait_idle("t2");
        ready_mode = 0;
        check_seq("t2", base, 1, 4);
        check("t2_word_cnt", 64'(word_cnt), 64'd4);
        check("t2_stall_stable", 64'(stall_viol), 64'd0);

        // 3: single beat with odd keep count; trailing byte dropped.
        push(3'd3, 1'b1, 32'hBEEF_CAFE);
        base = cap_n;
        run(16'd1);
        wait_idle("t3");
        check("t3_count", 64'(cap_n - base), 64'd1);
        check("t3_data", 64'(cap_data[base % 64]), 64'hCA_FE00);
        check("t3_last", 64'(cap_last[base % 64]), 64'd1);
        check("t3_err_odd", 64'(err_odd), 64'd1);
        check("t3_word_cnt", 64'(word_cnt), 64'd1);
        check("t3_err_len", 64'(err_len), 64'd0);

        // 4: expected length 3 but 4 words arrive.
        push(3'd4, 1'b0, 32'h0002_0001);
        push(3'd4, 1'b1, 32'h0004_0003);
        base = cap_n;
        run(16'd3);
        wait_idle("t4");
        check_seq("t4", base, 1, 4);
        check("t4_word_cnt", 64'(word_cnt), 64'd4);
        check("t4_err_len", 64'(err_len), 64'(LEN_CHK));
        check("t4_err_odd", 64'(err_odd), 64'd0);

        // 5: FIFO empty for 10 cycles after start, then a beat; second start ignored.
        base = cap_n;
        run(16'd2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t5_no_rd", 64'(bus_if.fifo_rd_en), 64'd0);
            check("t5_busy", 64'(busy), 64'd1);
        end
        tick();
        push(3'd4, 1'b1, 32'h0006_0005);
        tick();
        tick();
        run(16'd7);
        wait_idle("t5");
        check_seq("t5", base, 5, 2);
        check("t5_word_cnt", 64'(word_cnt), 64'd2);
        check("t5_err_len", 64'(err_len), 64'd0);
        tick();
        tick();
        check("t5_idle_after", 64'(busy), 64'd0);

        // 6: reset while stalled in UNPACK; next start uses the next FIFO entry.
        push(3'd4, 1'b1, 32'h0008_0007);
        push(3'd4, 1'b1, 32'h000A_0009);
        ready_mode = 2;
        run(16'd2);
        begin
            int n;
            n = 0;
            while (!bus_if.out_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("t6_valid_timeout", 64'(n >= 20), 64'd0);
        end
        check("t6_stalled_data", 64'(bus_if.out_data), 64'h00_0700);
        tick();
        rst = 1'b1;
        #1;
        check_zero_outputs("t6_rst");
        tick();
        tick();
        rst        = 1'b0;
        ready_mode = 0;
        tick();
        tick();
        base = cap_n;
        run(16'd2);
        wait_idle("t6");
        check_seq("t6", base, 9, 2);
        check("t6_word_cnt", 64'(word_cnt), 64'd2);
        check("t6_err_odd", 64'(err_odd), 64'd0);
        check("t6_fifo_drained", 64'(bus_if.fifo_empty), 64'd1);

        // Global handshake rules over the whole run.
        check("rd_while_empty", 64'(rd_empty), 64'd0);
        check("rd_during_unpack", 64'(rd_unpack), 64'd0);
        check("stall_stable_all", 64'(stall_viol), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
